// File: rtl/merge2_arb.sv
// merge2_arb: two-to-one flit merge with a paired source-token channel.
// Flits from In0/In1 are forwarded on the parent channel. Each flit is
// paired with a 1-bit token naming its source (0 = In0, 1 = In1). The flit
// and token registers drain independently. A new pair is loaded only once
// both halves of the previous pair have left, or leave on the same edge.
//
// Build option:
//   MERGE2_ARB_RR_EN defined   -> round-robin tie break using a one-bit
//                                 last-grant pointer.
//   MERGE2_ARB_RR_EN undefined -> fixed priority, In0 wins every tie.
module merge2_arb #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   // child 0
   input  logic         in0_valid,
   output logic         in0_ready,
   input  logic [W-1:0] in0_data,
   // child 1
   input  logic         in1_valid,
   output logic         in1_ready,
   input  logic [W-1:0] in1_data,
   // parent flit channel
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   // source token channel
   output logic         s_valid,
   input  logic         s_ready,
   output logic         s_data
);

   // Occupancy of the flit/token register pair.
   typedef enum logic [1:0] {
      ST_EMPTY    = 2'd0,  // both registers empty
      ST_BOTH     = 2'd1,  // flit and token pending
      ST_OUT_ONLY = 2'd2,  // token taken, flit pending
      ST_S_ONLY   = 2'd3   // flit taken, token pending
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   out_data_q, out_data_d;
   logic           s_data_q, s_data_d;

   logic           out_pending;
   logic           s_pending;
   logic           out_drain;
   logic           s_drain;
   logic           can_load;
   logic           grant0;
   logic           grant1;
   logic           load;

`ifdef MERGE2_ARB_RR_EN
   // 1 = In1 was granted last, so In0 wins the next tie.
   logic           ptr_q, ptr_d;
`endif

   // Decode register occupancy and which halves drain this cycle.
   always_comb begin
      out_pending = (state_q == ST_BOTH) || (state_q == ST_OUT_ONLY);
      s_pending   = (state_q == ST_BOTH) || (state_q == ST_S_ONLY);
      out_drain   = out_pending && out_ready;
      s_drain     = s_pending && s_ready;
      // A load is allowed only when every pending half leaves on this edge.
      can_load    = (state_q == ST_EMPTY) ||
                    ((!out_pending || out_ready) && (!s_pending || s_ready));
   end

   // Pick at most one input; ties resolved by the configured policy.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (in0_valid && in1_valid) begin
`ifdef MERGE2_ARB_RR_EN
         if (ptr_q) begin
            grant0 = 1'b1;
         end else begin
            grant1 = 1'b1;
         end
`else
         grant0 = 1'b1;
`endif
      end else if (in0_valid) begin
         grant0 = 1'b1;
      end else if (in1_valid) begin
         grant1 = 1'b1;
      end
   end

   // Ready only to the granted input; held low while reset is asserted.
   always_comb begin
      in0_ready = rst_n && can_load && grant0;
      in1_ready = rst_n && can_load && grant1;
      load      = in0_ready || in1_ready;
   end

   // Next state and next contents of the flit/token registers.
   always_comb begin
      state_d    = state_q;
      out_data_d = out_data_q;
      s_data_d   = s_data_q;
      if (load) begin
         // Drain-and-load, or load from empty: a fresh pair in both halves.
         state_d    = ST_BOTH;
         out_data_d = grant1 ? in1_data : in0_data;
         s_data_d   = grant1;
      end else begin
         case (state_q)
            ST_BOTH: begin
               if (out_drain && s_drain) begin
                  state_d = ST_EMPTY;
               end else if (s_drain) begin
                  state_d = ST_OUT_ONLY;
               end else if (out_drain) begin
                  state_d = ST_S_ONLY;
               end
            end
            ST_OUT_ONLY: begin
               if (out_drain) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_S_ONLY: begin
               if (s_drain) begin
                  state_d = ST_EMPTY;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

`ifdef MERGE2_ARB_RR_EN
   // Pointer follows the winner, only on an accepted transfer.
   always_comb begin
      ptr_d = ptr_q;
      if (load) begin
         ptr_d = grant1;
      end
   end

   // Round-robin pointer register; reset so In0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b1;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   // State and output data registers; reset discards any pending pair.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         out_data_q <= '0;
         s_data_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_data_q <= out_data_d;
         s_data_q   <= s_data_d;
      end
   end

   // Output valids come straight from the occupancy state.
   always_comb begin
      out_valid = out_pending;
      s_valid   = s_pending;
      out_data  = out_data_q;
      s_data    = s_data_q;
   end

endmodule

// File: tb/tb_merge2_arb.sv
// tb_merge2_arb: table-driven check of merge2_arb plus a hand-written
// streaming sequence. Inputs are driven on the falling edge and outputs are
// sampled 1 ns later, so each vector sees the registered state left by the
// previous rising edge together with the combinational readies.
module tb_merge2_arb;

`ifdef MERGE2_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       in0_valid, in0_ready;
   logic [8:0] in0_data;
   logic       in1_valid, in1_ready;
   logic [8:0] in1_data;
   logic       out_valid, out_ready;
   logic [8:0] out_data;
   logic       s_valid, s_ready, s_data;

   int checks   = 0;
   int failures = 0;

   merge2_arb #(.W(9)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in0_valid (in0_valid),
      .in0_ready (in0_ready),
      .in0_data  (in0_data),
      .in1_valid (in1_valid),
      .in1_ready (in1_ready),
      .in1_data  (in1_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       v0;
      logic [8:0] d0;
      logic       v1;
      logic [8:0] d1;
      logic       ordy;
      logic       srdy;
      logic       e_r0;
      logic       e_r1;
      logic       e_ov;
      logic [8:0] e_od;
      logic       e_sv;
      logic       e_sd;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic rst, input logic v0, input logic [8:0] d0,
                               input logic v1, input logic [8:0] d1,
                               input logic ordy, input logic srdy,
                               input logic e_r0, input logic e_r1,
                               input logic e_ov, input logic [8:0] e_od,
                               input logic e_sv, input logic e_sd);
      vec_t v;
      v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
      v.ordy = ordy; v.srdy = srdy;
      v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_ov = e_ov; v.e_od = e_od;
      v.e_sv = e_sv; v.e_sd = e_sd;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [8:0] got, input logic [8:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s vec=%0d got=0x%03h exp=0x%03h", name, idx, got, exp);
      end
   endtask

   initial begin
      // reset phase: rst, v0,d0, v1,d1, ordy,srdy | r0,r1, ov,od, sv,sd
      tbl.push_back(mk(0, 1, 9'h1A3, 0, 9'h000, 1, 1,  0, 0,  0, 9'h000, 0, 0)); // R0
      // first accept right after release
      tbl.push_back(mk(1, 1, 9'h1A3, 0, 9'h000, 1, 1,  1, 0,  0, 9'h000, 0, 0)); // V0
      // In1 streaming, no bubbles
      tbl.push_back(mk(1, 0, 9'h000, 1, 9'h0F0, 1, 1,  0, 1,  1, 9'h1A3, 1, 0)); // V1
      tbl.push_back(mk(1, 0, 9'h000, 1, 9'h0F1, 1, 1,  0, 1,  1, 9'h0F0, 1, 1)); // V2
      tbl.push_back(mk(1, 0, 9'h000, 1, 9'h0F2, 1, 1,  0, 1,  1, 9'h0F1, 1, 1)); // V3
      tbl.push_back(mk(1, 0, 9'h000, 0, 9'h000, 1, 1,  0, 0,  1, 9'h0F2, 1, 1)); // V4
      tbl.push_back(mk(1, 0, 9'h000, 0, 9'h000, 1, 1,  0, 0,  0, 9'h000, 0, 0)); // V5
      // ties: In0=0x100, In1=0x155
      tbl.push_back(mk(1, 1, 9'h100, 1, 9'h155, 1, 1,  1, 0,  0, 9'h000, 0, 0)); // V6
      tbl.push_back(mk(1, 1, 9'h100, 1, 9'h155, 1, 1,  !RR, RR, 1, 9'h100, 1, 0)); // V7
      tbl.push_back(mk(1, 1, 9'h100, 1, 9'h155, 1, 1,  1, 0,  1, RR ? 9'h155 : 9'h100, 1, RR)); // V8
      tbl.push_back(mk(1, 1, 9'h100, 1, 9'h155, 1, 1,  !RR, RR, 1, 9'h100, 1, 0)); // V9
      tbl.push_back(mk(1, 0, 9'h000, 0, 9'h000, 1, 1,  0, 0,  1, RR ? 9'h155 : 9'h100, 1, RR)); // V10
      // split drain: token stalled for 3 cycles
      tbl.push_back(mk(1, 1, 9'h0AA, 0, 9'h000, 1, 1,  1, 0,  0, 9'h000, 0, 0)); // V11
      tbl.push_back(mk(1, 1, 9'h0BB, 0, 9'h000, 1, 0,  0, 0,  1, 9'h0AA, 1, 0)); // V12
      tbl.push_back(mk(1, 1, 9'h0BB, 0, 9'h000, 1, 0,  0, 0,  0, 9'h000, 1, 0)); // V13
      tbl.push_back(mk(1, 1, 9'h0BB, 0, 9'h000, 1, 0,  0, 0,  0, 9'h000, 1, 0)); // V14
      tbl.push_back(mk(1, 1, 9'h0BB, 0, 9'h000, 1, 1,  1, 0,  0, 9'h000, 1, 0)); // V15
      // flit stalled, token drains -> OUT_ONLY
      tbl.push_back(mk(1, 0, 9'h000, 0, 9'h000, 0, 1,  0, 0,  1, 9'h0BB, 1, 0)); // V16
      tbl.push_back(mk(1, 0, 9'h000, 1, 9'h0CC, 0, 1,  0, 1'b0, 1, 9'h0BB, 0, 0)); // V17
      // reset while in OUT_ONLY: valids drop before any rising edge
      tbl.push_back(mk(0, 0, 9'h000, 1, 9'h0CC, 1, 1,  0, 0,  0, 9'h000, 0, 0)); // R1
      tbl.push_back(mk(0, 0, 9'h000, 1, 9'h0CC, 1, 1,  0, 0,  0, 9'h000, 0, 0)); // R2
      // after release: correct token, then first tie goes to In0
      tbl.push_back(mk(1, 0, 9'h000, 1, 9'h0CC, 1, 1,  0, 1,  0, 9'h000, 0, 0)); // P0
      tbl.push_back(mk(1, 1, 9'h100, 1, 9'h155, 1, 1,  1, 0,  1, 9'h0CC, 1, 1)); // P1
      tbl.push_back(mk(1, 0, 9'h000, 0, 9'h000, 1, 1,  0, 0,  1, 9'h100, 1, 0)); // P2
      tbl.push_back(mk(1, 0, 9'h000, 0, 9'h000, 1, 1,  0, 0,  0, 9'h000, 0, 0)); // P3

      rst_n = 1'b0;
      in0_valid = 1'b0; in0_data = '0;
      in1_valid = 1'b0; in1_data = '0;
      out_ready = 1'b0; s_ready = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         rst_n     = tbl[i].rst;
         in0_valid = tbl[i].v0;
         in0_data  = tbl[i].d0;
         in1_valid = tbl[i].v1;
         in1_data  = tbl[i].d1;
         out_ready = tbl[i].ordy;
         s_ready   = tbl[i].srdy;
         #1;
         chk("in0_ready", i, {8'd0, in0_ready}, {8'd0, tbl[i].e_r0});
         chk("in1_ready", i, {8'd0, in1_ready}, {8'd0, tbl[i].e_r1});
         chk("out_valid", i, {8'd0, out_valid}, {8'd0, tbl[i].e_ov});
         chk("s_valid",   i, {8'd0, s_valid},   {8'd0, tbl[i].e_sv});
         if (tbl[i].e_ov || !tbl[i].rst) begin
            chk("out_data", i, out_data, tbl[i].e_od);
         end
         if (tbl[i].e_sv || !tbl[i].rst) begin
            chk("s_data", i, {8'd0, s_data}, {8'd0, tbl[i].e_sd});
         end
         $display("vec %0d: rst_n=%0b r0=%0b r1=%0b ov=%0b od=0x%03h sv=%0b sd=%0b",
                  i, rst_n, in0_ready, in1_ready, out_valid, out_data, s_valid, s_data);
      end

      // Hand-written stream: In1 offers four flits back to back; each must
      // appear on consecutive cycles with token 1 and no bubbles.
      begin
         logic [8:0] src[4];
         int idx;
         int out_cnt;
         int cyc;
         src[0] = 9'h0F0; src[1] = 9'h0F1; src[2] = 9'h0F2; src[3] = 9'h0F3;
         idx = 0; out_cnt = 0; cyc = 0;
         in0_valid = 1'b0;
         for (cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            in1_valid = (idx < 4);
            in1_data  = (idx < 4) ? src[idx] : 9'h000;
            #1;
            if (out_valid) begin
               chk("stream_data", out_cnt, out_data, src[out_cnt]);
               chk("stream_tok", out_cnt, {8'd0, s_data}, 9'd1);
               $display("stream %0d: out_data=0x%03h s_data=%0b", out_cnt, out_data, s_data);
               out_cnt++;
            end
            if (in1_ready) idx++;
            if (out_cnt == 4) break;
         end
         chk("stream_count", 0, out_cnt[8:0], 9'd4);
         chk("stream_cycles", 0, cyc[8:0], 9'd4);
         @(negedge clk);
         in1_valid = 1'b0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
